// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32I subset fields into 32-bit instruction
// words, buffers them in a FIFO and presents them with a sequential word
// address for loading into instruction memory.
module instr_encoder #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 12
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_op,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_rs1,
  input  logic [4:0]               in_rs2,
  input  logic [11:0]              in_imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [ADDR_W-1:0]        out_addr,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  // Mnemonic codes as presented on in_op; 10..15 are illegal.
  typedef enum logic [3:0] {
    OP_LW   = 4'd0,
    OP_SW   = 4'd1,
    OP_BEQ  = 4'd2,
    OP_ADD  = 4'd3,
    OP_SUB  = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_SRL  = 4'd7,
    OP_ANDI = 4'd8,
    OP_ORI  = 4'd9
  } op_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;

  logic [31:0]       mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              err_reg;

  logic [31:0]       enc_word;
  logic              legal;
  logic              accept;
  logic              push;
  logic              pop;

  // Flow control derives only from registered occupancy.
  assign in_ready  = (count_reg != FULL_COUNT);
  assign out_valid = (count_reg != '0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && legal;
  assign pop       = out_valid && out_ready;

  assign out_instr = out_valid ? mem[rd_ptr_reg] : 32'h0;
  assign out_addr  = addr_reg;
  assign err       = err_reg;
  assign count     = count_reg;

  // Combinational field packing and legality check of the offered bundle.
  always_comb begin
    enc_word = 32'h0;
    legal    = 1'b1;
    case (in_op)
      OP_LW:   enc_word = {in_imm, in_rs1, 3'b010, in_rd, OPC_LOAD};
      OP_SW:   enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010,
                           in_imm[4:0], OPC_STORE};
      OP_BEQ: begin
        // The 13-bit branch offset is in_imm sign-extended, so both
        // offset bits 12 and 11 come from in_imm[11]; an odd offset
        // cannot be represented.
        enc_word = {in_imm[11], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                    in_imm[4:1], in_imm[11], OPC_BRANCH};
        legal    = !in_imm[0];
      end
      OP_ADD:  enc_word = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, OPC_RTYPE};
      OP_SUB:  enc_word = {7'b0100000, in_rs2, in_rs1, 3'b000, in_rd, OPC_RTYPE};
      OP_AND:  enc_word = {7'b0000000, in_rs2, in_rs1, 3'b111, in_rd, OPC_RTYPE};
      OP_OR:   enc_word = {7'b0000000, in_rs2, in_rs1, 3'b110, in_rd, OPC_RTYPE};
      OP_SRL:  enc_word = {7'b0000000, in_rs2, in_rs1, 3'b101, in_rd, OPC_RTYPE};
      OP_ANDI: enc_word = {in_imm, in_rs1, 3'b111, in_rd, OPC_ITYPE};
      OP_ORI:  enc_word = {in_imm, in_rs1, 3'b110, in_rd, OPC_ITYPE};
      default: legal = 1'b0;
    endcase
  end

  // FIFO storage write; data needs no reset since out_instr is gated by out_valid.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      mem[wr_ptr_reg] <= enc_word;
    end
  end

  // Pointers, occupancy, head address and the rejection pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      addr_reg   <= '0;
      err_reg    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        addr_reg   <= addr_reg + ADDR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
      err_reg <= accept && !legal;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vector table plus hand-written sequences for
// FIFO full/drain and mid-operation reset.
module tb_instr_encoder;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [11:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [11:0] out_addr;
  logic        err;
  logic [3:0]  count;

  int checks   = 0;
  int failures = 0;

  instr_encoder #(.DEPTH(8), .ADDR_W(12)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .err       (err),
    .count     (count)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] imm;
    logic        exp_err;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [11:0] imm);
    in_valid = 1'b1;
    in_op    = op;
    in_rd    = rd;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_imm   = imm;
  endtask

  logic [31:0] full_exp [9];
  logic [11:0] exp_addr;
  logic [11:0] base;

  initial begin
    vecs[0]  = '{"ADD",        4'd3,  5'd3,  5'd1,  5'd2, 12'h000, 1'b0, 32'h002081B3};
    vecs[1]  = '{"LW",         4'd0,  5'd5,  5'd0,  5'd0, 12'h008, 1'b0, 32'h00802283};
    vecs[2]  = '{"SW",         4'd1,  5'd7,  5'd0,  5'd5, 12'h00C, 1'b0, 32'h00502623};
    vecs[3]  = '{"BEQ_m4",     4'd2,  5'd0,  5'd1,  5'd2, 12'hFFC, 1'b0, 32'hFE208EE3};
    vecs[4]  = '{"BEQ_odd",    4'd2,  5'd0,  5'd1,  5'd2, 12'h003, 1'b1, 32'h0};
    vecs[5]  = '{"OP15",       4'd15, 5'd1,  5'd1,  5'd1, 12'h000, 1'b1, 32'h0};
    vecs[6]  = '{"SUB",        4'd4,  5'd3,  5'd1,  5'd2, 12'h000, 1'b0, 32'h402081B3};
    vecs[7]  = '{"AND",        4'd5,  5'd3,  5'd1,  5'd2, 12'h000, 1'b0, 32'h0020F1B3};
    vecs[8]  = '{"OR",         4'd6,  5'd3,  5'd1,  5'd2, 12'h000, 1'b0, 32'h0020E1B3};
    vecs[9]  = '{"SRL",        4'd7,  5'd3,  5'd1,  5'd2, 12'h000, 1'b0, 32'h0020D1B3};
    vecs[10] = '{"ANDI",       4'd8,  5'd3,  5'd1,  5'd2, 12'h0FF, 1'b0, 32'h0FF0F193};
    vecs[11] = '{"ORI",        4'd9,  5'd3,  5'd1,  5'd0, 12'h800, 1'b0, 32'h8000E193};
    vecs[12] = '{"BEQ_p8",     4'd2,  5'd0,  5'd0,  5'd0, 12'h008, 1'b0, 32'h00000463};
    vecs[13] = '{"LW_max",     4'd0,  5'd31, 5'd31, 5'd0, 12'hFFF, 1'b0, 32'hFFFFAF83};
    vecs[14] = '{"OP10",       4'd10, 5'd0,  5'd0,  5'd0, 12'h000, 1'b1, 32'h0};

    // Reset state
    reset = 1'b1; out_ready = 1'b1;
    drive(4'd0, 5'd0, 5'd0, 5'd0, 12'h0); in_valid = 1'b0;
    @(negedge clock); @(negedge clock);
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_addr", 32'(out_addr), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_instr", out_instr, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Table-driven single transactions with out_ready held high
    exp_addr = '0;
    for (int i = 0; i < 15; i++) begin
      check({vecs[i].name, "_in_ready"}, 32'(in_ready), 32'd1);
      check({vecs[i].name, "_no_bypass"}, 32'(out_valid), 32'd0);
      drive(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
      @(negedge clock);
      in_valid = 1'b0;
      $display("vec %0d %s: out_valid=%0d instr=0x%08h addr=%0d err=%0d count=%0d",
               i, vecs[i].name, out_valid, out_instr, out_addr, err, count);
      check({vecs[i].name, "_err"}, 32'(err), 32'(vecs[i].exp_err));
      if (vecs[i].exp_err) begin
        check({vecs[i].name, "_count"}, 32'(count), 32'd0);
        check({vecs[i].name, "_out_valid"}, 32'(out_valid), 32'd0);
      end else begin
        check({vecs[i].name, "_out_valid"}, 32'(out_valid), 32'd1);
        check({vecs[i].name, "_instr"}, out_instr, vecs[i].exp_instr);
        check({vecs[i].name, "_addr"}, 32'(out_addr), 32'(exp_addr));
        exp_addr = exp_addr + 12'd1;
      end
      @(negedge clock);
      check({vecs[i].name, "_err_cleared"}, 32'(err), 32'd0);
      check({vecs[i].name, "_drained"}, 32'(count), 32'd0);
    end

    // Fill to full with out_ready low, offer a ninth bundle
    base = exp_addr;
    for (int i = 0; i < 9; i++) full_exp[i] = (32'(i + 1) << 7) | 32'h33;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(4'd3, 5'(i + 1), 5'd0, 5'd0, 12'h0);
      @(negedge clock);
    end
    $display("full: count=%0d in_ready=%0d head=0x%08h addr=%0d", count, in_ready, out_instr, out_addr);
    check("full_count", 32'(count), 32'd8);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_head", out_instr, full_exp[0]);
    check("full_addr", 32'(out_addr), 32'(base));
    drive(4'd3, 5'd9, 5'd0, 5'd0, 12'h0);
    @(negedge clock);
    check("full_blocked_count", 32'(count), 32'd8);
    check("full_stable_head", out_instr, full_exp[0]);
    check("full_stable_addr", 32'(out_addr), 32'(base));
    out_ready = 1'b1;
    @(negedge clock);
    check("after_pop_count", 32'(count), 32'd7);
    check("after_pop_in_ready", 32'(in_ready), 32'd1);
    check("after_pop_head", out_instr, full_exp[1]);
    @(negedge clock);
    in_valid = 1'b0;
    check("push_pop_count", 32'(count), 32'd7);
    for (int k = 2; k < 9; k++) begin
      $display("drain %0d: instr=0x%08h addr=%0d", k, out_instr, out_addr);
      check("drain_valid", 32'(out_valid), 32'd1);
      check("drain_instr", out_instr, full_exp[k]);
      check("drain_addr", 32'(out_addr), 32'(base + 12'(k)));
      @(negedge clock);
    end
    check("drain_empty", 32'(count), 32'd0);
    check("drain_out_valid", 32'(out_valid), 32'd0);

    // Reset with five buffered words and a handshake in the reset cycle
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(4'd5, 5'(i), 5'd1, 5'd2, 12'h0);
      @(negedge clock);
    end
    in_valid = 1'b0;
    check("prerst_count", 32'(count), 32'd5);
    reset = 1'b1;
    drive(4'd3, 5'd3, 5'd1, 5'd2, 12'h0);
    @(negedge clock);
    reset = 1'b0; in_valid = 1'b0;
    $display("midrst: count=%0d out_valid=%0d addr=%0d in_ready=%0d", count, out_valid, out_addr, in_ready);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_addr", 32'(out_addr), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_instr", out_instr, 32'd0);

    // First word after reset starts again at address 0
    out_ready = 1'b1;
    drive(4'd4, 5'd3, 5'd1, 5'd2, 12'h0);
    @(negedge clock);
    in_valid = 1'b0;
    $display("postrst: instr=0x%08h addr=%0d", out_instr, out_addr);
    check("postrst_instr", out_instr, 32'h402081B3);
    check("postrst_addr", 32'(out_addr), 32'd0);
    @(negedge clock);
    check("postrst_drained", 32'(count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Instruction encoder for the RV32I subset executed by the datapath: LW, SW, BEQ, ADD, SUB, AND, OR, SRL, ANDI, ORI. It accepts decoded fields (mnemonic code, registers, immediate) over a valid/ready handshake and packs them into 32-bit RISC-V words. Words are buffered in a FIFO and emitted with a sequential word address, ready to be written into instruction memory. It is the inverse of the control/immediate decoder and produces the words that decoder consumes.

## Interface
Parameters:
- DEPTH, 8: FIFO entries; power of 2, at least 2.
- ADDR_W, 12: width of out_addr, matching the program-line width.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  field bundle present.
- in_ready  out  1  encoder can accept; equals !full.
- in_op  in  4  0=LW 1=SW 2=BEQ 3=ADD 4=SUB 5=AND 6=OR 7=SRL 8=ANDI 9=ORI; 10..15 illegal.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_imm  in  12  signed immediate; byte offset for BEQ.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes head.
- out_instr  out  32  encoded word at FIFO head.
- out_addr  out  ADDR_W  word address of head.
- err  out  1  one-cycle pulse on rejected bundle.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Accept when in_valid && in_ready. Encoding is combinational from the inputs. A legal word is written to the FIFO tail on the same edge.
- Encodings (opcode, funct3, funct7):
  - LW: imm[11:0]|rs1|010|rd|0000011.
  - SW: imm[11:5]|rs2|rs1|010|imm[4:0]|0100011.
  - BEQ: in_imm is sign-extended to 13 bits; fields imm[12]|imm[10:5]|rs2|rs1|000|imm[4:1]|imm[11]|1100011.
  - R-type, opcode 0110011: ADD 0000000/000, SUB 0100000/000, AND 0000000/111, OR 0000000/110, SRL 0000000/101.
  - ANDI/ORI: imm[11:0]|rs1|111 or 110|rd|0010011.
  - Fields unused by a format are ignored. x0 is encoded as given.
- Rejected bundles (illegal in_op, or BEQ with in_imm[0]=1):
  - Still consumed (the handshake completes).
  - Nothing is written to the FIFO and the address does not advance.
  - err=1 on the following cycle only.
- Pop when out_valid && out_ready. out_addr increments by 1 per pop and wraps modulo 2^ADDR_W.
- Simultaneous push and pop: both happen and count is unchanged.
- Push is never allowed while full, even if a pop occurs in the same cycle, because in_ready = !full.
- Pointers wrap modulo DEPTH.

## Timing
- Reset values: FIFO pointers=0, count=0, out_valid=0, out_addr=0, err=0, in_ready=1, out_instr=0.
- Reset mid-operation discards all buffered words. A handshake in the reset cycle is ignored.
- Latency from accept to out_valid is 1 cycle. There is no bypass when the FIFO is empty.
- out_valid = (count != 0). out_instr and out_addr are stable while out_valid && !out_ready.
- in_ready depends only on the registered count, with no combinational path from in_valid or out_ready.
- At full (count == DEPTH), in_ready=0. It returns to 1 the cycle after a pop.

## Test plan
- ADD rd=3 rs1=1 rs2=2, out_ready=1 → out_instr=0x002081B3, out_addr=0, out_valid 1 cycle after accept.
- LW rd=5 rs1=0 imm=8, then SW rs2=5 rs1=0 imm=12 → 0x00802283 at addr 0, then 0x00502623 at addr 1.
- BEQ rs1=1 rs2=2 imm=-4 (0xFFC) → 0xFE208EE3. BEQ imm=3 → err pulse, count unchanged.
- in_op=15 → err=1 for exactly one cycle, no FIFO write, the next legal word keeps the expected address.
- out_ready=0 with 9 bundles offered → 8 accepted, in_ready=0, count=8. Raise out_ready → 8 words drain in order at addr 0..7, and the 9th is accepted after the first pop.
- Reset asserted with count=5 → next cycle count=0, out_valid=0, out_addr=0, in_ready=1.
